uart_cfg: RTL and testbench

Runtime-configurable UART with 16x oversampling, internal TX and RX FIFOs, optional even/odd parity, 1 or 2 stop bits, and an internal loopback mode. Each received word is stored with its parity-error and framing-error flags, and receive overrun is reported through a sticky flag. It is the drop-in successor to the fixed-format UART on the MMIO UART slot, with baud rate and frame format programmable from registers instead of fixed at elaboration.

---
 rtl/uart_cfg.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - runtime-configurable 16x-oversampled UART with TX/RX FIFOs
// Frame format and baud divisor come from inputs; each RX entry carries its parity/framing flags.

module uart_cfg_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] w_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr_nxt;
  logic [AW-1:0] rptr_nxt;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok    = wr && !full;
  assign rd_ok    = rd && !empty;
  assign wptr_nxt = wptr + 1'b1;
  assign rptr_nxt = rptr + 1'b1;
  assign rd_data  = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_ok) mem[wptr] <= w_data;
      case ({wr_ok, rd_ok})
        2'b01: begin
          rptr  <= rptr_nxt;
          full  <= 1'b0;
          empty <= (rptr_nxt == wptr);
        end
        2'b10: begin
          wptr  <= wptr_nxt;
          empty <= 1'b0;
          full  <= (wptr_nxt == rptr);
        end
        2'b11: begin
          wptr <= wptr_nxt;
          rptr <= rptr_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

module uart_cfg #(
  parameter int DBIT   = 8,
  parameter int DVSR_W = 11,
  parameter int FIFO_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic              loopback,
  input  logic              rx,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd_uart,
  input  logic              clr_err,
  output logic              tx,
  output logic              tx_full,
  output logic              tx_busy,
  output logic              rx_empty,
  output logic [DBIT-1:0]   r_data,
  output logic              r_perr,
  output logic              r_ferr,
  output logic              overrun
);
  localparam int NW = $clog2(DBIT);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Baud tick: >= so that lowering dvsr below the running count wraps at once.
  logic [DVSR_W-1:0] baud_cnt;
  logic              tick;

  assign tick = (baud_cnt >= dvsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) baud_cnt <= '0;
    else       baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
  end

  // TX path
  logic [DBIT-1:0] tx_head;
  logic            tx_empty;
  logic            tx_pop;
  state_t          tx_state;
  logic [4:0]      tx_s;
  logic [NW-1:0]   tx_n;
  logic [DBIT-1:0] tx_shreg;
  logic            tx_par;
  logic            tx_pen;
  logic            tx_stop2;
  logic            tx_reg;
  logic [4:0]      tx_stop_last;

  assign tx_pop       = (tx_state == S_IDLE) && !tx_empty;
  assign tx_stop_last = tx_stop2 ? 5'd31 : 5'd15;

  uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr_uart),
    .rd      (tx_pop),
    .w_data  (w_data),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_reg   <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx_reg <= 1'b1;
          if (!tx_empty) begin
            tx_shreg <= tx_head;
            tx_par   <= ^tx_head ^ parity_odd;
            tx_pen   <= parity_en;
            tx_stop2 <= stop2;
            tx_s     <= '0;
            tx_reg   <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: if (tick) begin
          if (tx_s == 5'd15) begin
            tx_s     <= '0;
            tx_n     <= '0;
            tx_reg   <= tx_shreg[0];
            tx_state <= S_DATA;
          end else begin
            tx_s <= tx_s + 5'd1;
          end
        end
        S_DATA: if (tick) begin
          if (tx_s == 5'd15) begin
            tx_s     <= '0;
            tx_shreg <= tx_shreg >> 1;
            if (tx_n == N_LAST) begin
              tx_reg   <= tx_pen ? tx_par : 1'b1;
              tx_state <= tx_pen ? S_PARITY : S_STOP;
            end else begin
              tx_n   <= tx_n + 1'b1;
              tx_reg <= tx_shreg[1];
            end
          end else begin
            tx_s <= tx_s + 5'd1;
          end
        end
        S_PARITY: if (tick) begin
          if (tx_s == 5'd15) begin
            tx_s     <= '0;
            tx_reg   <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            tx_s <= tx_s + 5'd1;
          end
        end
        S_STOP: if (tick) begin
          if (tx_s == tx_stop_last) begin
            tx_s     <= '0;
            tx_state <= S_IDLE;
          end else begin
            tx_s <= tx_s + 5'd1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  assign tx      = loopback | tx_reg;
  assign tx_busy = (tx_state != S_IDLE) || !tx_empty;

  // RX path
  logic            rx_meta;
  logic            rx_sync;
  logic            rx_src;
  state_t          rx_state;
  logic [3:0]      rx_s;
  logic [NW-1:0]   rx_n;
  logic [DBIT-1:0] rx_data;
  logic            rx_pen;
  logic            rx_podd;
  logic            rx_perr;
  logic            rx_wr;
  logic [DBIT+1:0] rx_word;
  logic [DBIT+1:0] rx_head;
  logic            rx_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign rx_src = loopback ? tx_reg : rx_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_data  <= '0;
      rx_pen   <= 1'b0;
      rx_podd  <= 1'b0;
      rx_perr  <= 1'b0;
      rx_wr    <= 1'b0;
      rx_word  <= '0;
    end else begin
      rx_wr <= 1'b0;
      case (rx_state)
        S_IDLE: if (!rx_src) begin
          rx_s     <= '0;
          rx_pen   <= parity_en;
          rx_podd  <= parity_odd;
          rx_perr  <= 1'b0;
          rx_state <= S_START;
        end
        S_START: if (tick) begin
          if (rx_s == 4'd7) begin
            rx_s     <= '0;
            rx_n     <= '0;
            rx_state <= rx_src ? S_IDLE : S_DATA;
          end else begin
            rx_s <= rx_s + 4'd1;
          end
        end
        S_DATA: if (tick) begin
          if (rx_s == 4'd15) begin
            rx_s    <= '0;
            rx_data <= {rx_src, rx_data[DBIT-1:1]};
            if (rx_n == N_LAST) rx_state <= rx_pen ? S_PARITY : S_STOP;
            else                rx_n     <= rx_n + 1'b1;
          end else begin
            rx_s <= rx_s + 4'd1;
          end
        end
        S_PARITY: if (tick) begin
          if (rx_s == 4'd15) begin
            rx_s     <= '0;
            rx_perr  <= rx_src != (^rx_data ^ rx_podd);
            rx_state <= S_STOP;
          end else begin
            rx_s <= rx_s + 4'd1;
          end
        end
        S_STOP: if (tick) begin
          if (rx_s == 4'd15) begin
            rx_s     <= '0;
            rx_wr    <= 1'b1;
            rx_word  <= {~rx_src, rx_perr, rx_data};
            rx_state <= S_IDLE;
          end else begin
            rx_s <= rx_s + 4'd1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  uart_cfg_fifo #(.W(DBIT + 2), .AW(FIFO_W)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_wr),
    .rd      (rd_uart),
    .w_data  (rx_word),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign {r_ferr, r_perr, r_data} = rx_head;

  // A drop in the same clk as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                overrun <= 1'b0;
    else if (rx_wr && rx_full) overrun <= 1'b1;
    else if (clr_err)         overrun <= 1'b0;
  end
endmodule

// File: tb/tb_uart_cfg.sv
// tb/tb_uart_cfg.sv - directed and randomized bench for uart_cfg
// Expected RX entries come from a queue built from the frames the bench itself sends.

module tb_uart_cfg;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic        parity_en, parity_odd, stop2, loopback, rx;
  logic        wr_uart, rd_uart, clr_err;
  logic [7:0]  w_data;
  logic        tx, tx_full, tx_busy, rx_empty, r_perr, r_ferr, overrun;
  logic [7:0]  r_data;

  int tests = 0;
  int fails = 0;
  int bit_clks = 16;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  uart_cfg dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .parity_en(parity_en), .parity_odd(parity_odd),
    .stop2(stop2), .loopback(loopback), .rx(rx), .wr_uart(wr_uart), .w_data(w_data),
    .rd_uart(rd_uart), .clr_err(clr_err), .tx(tx), .tx_full(tx_full), .tx_busy(tx_busy),
    .rx_empty(rx_empty), .r_data(r_data), .r_perr(r_perr), .r_ferr(r_ferr), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_dvsr(input int v);
    dvsr = 11'(v);
    bit_clks = 16 * (v + 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx"}, tx, 1);
    check({tag, "_tx_full"}, tx_full, 0);
    check({tag, "_tx_busy"}, tx_busy, 0);
    check({tag, "_rx_empty"}, rx_empty, 1);
    check({tag, "_r_data"}, r_data, 0);
    check({tag, "_r_perr"}, r_perr, 0);
    check({tag, "_r_ferr"}, r_ferr, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rx = 1'b1;
    reset = 1'b1;
    steps(2);
    check_reset_vals(tag);
    reset = 1'b0;
    step();
  endtask

  // Serial frame on rx: start, LSB-first data, optional parity, one stop.
  // A bad stop bit is held low for 3/4 of a bit so the trailing low reads as a false start.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit po,
                            input bit bad_par, input bit bad_stop, input int cut);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pe) b.push_back(^d ^ po ^ bad_par);
    b.push_back(!bad_stop);
    for (int i = 0; i < b.size() && i < cut; i++) begin
      rx = b[i];
      if (i == b.size() - 1 && bad_stop) begin
        steps(bit_clks * 3 / 4);
        rx = 1'b1;
        steps(bit_clks / 4);
      end else begin
        steps(bit_clks);
      end
    end
    rx = 1'b1;
    if (cut >= b.size()) steps(2 * bit_clks);
  endtask

  task automatic check_head(input string tag);
    logic [9:0] e;
    e = exp_q.pop_front();
    check({tag, "_not_empty"}, rx_empty, 0);
    check({tag, "_data"}, r_data, e[7:0]);
    check({tag, "_perr"}, r_perr, e[8]);
    check({tag, "_ferr"}, r_ferr, e[9]);
    rd_uart = 1'b1;
    step();
    rd_uart = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, d1;
    logic [7:0] lb_words [5];
    bit pe, po, bp, bs;
    int n;
    logic exp_bit;

    reset = 1'b1; rx = 1'b1; wr_uart = 1'b0; rd_uart = 1'b0; clr_err = 1'b0; w_data = '0;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; loopback = 1'b0;
    set_dvsr(0);
    steps(2);
    check_reset_vals("reset");
    reset = 1'b0;
    step();

    // 8N1 frame of 0xA5 at one tick per clk
    d1 = 8'hA5;
    w_data = d1; wr_uart = 1'b1; step(); wr_uart = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 8) begin step(); n++; end
    check("t1_start_seen", tx, 0);
    for (int k = 0; k < 160; k++) begin
      int idx;
      idx = k / 16;
      exp_bit = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : d1[idx-1];
      check("t1_tx_bit", tx, exp_bit);
      if (k == 159) check("t1_busy_in_stop", tx_busy, 1);
      step();
    end
    check("t1_busy_done", tx_busy, 0);
    check("t1_tx_idle", tx, 1);

    // Loopback 8E2, five words back-to-back; the fifth fills the TX FIFO
    loopback = 1'b1; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
    lb_words = '{8'h3C, 8'h81, 8'hFF, 8'h00, 8'h5A};
    for (int i = 0; i < 5; i++) begin
      w_data = lb_words[i]; wr_uart = 1'b1; step();
      exp_q.push_back({2'b00, lb_words[i]});
    end
    wr_uart = 1'b0;
    check("t2_tx_full", tx_full, 1);
    check("t2_tx_pin_high", tx, 1);
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (rx_empty !== 1'b0 && n < 400) begin step(); n++; end
      check("t2_tx_pin_held", tx, 1);
      check_head("t2_lb");
    end
    n = 0;
    while (tx_busy !== 1'b0 && n < 400) begin step(); n++; end
    check("t2_tx_done", tx_busy, 0);
    check("t2_rx_drained", rx_empty, 1);
    check("t2_no_overrun", overrun, 0);
    loopback = 1'b0; stop2 = 1'b0;
    step();

    // External rx, even parity: bad parity, then bad stop
    set_dvsr(1);
    parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h55, 1, 0, 1, 0, 99);
    exp_q.push_back({1'b0, 1'b1, 8'h55});
    check_head("t3_bad_par");
    send_frame(8'h55, 1, 0, 0, 1, 99);
    exp_q.push_back({1'b1, 1'b0, 8'h55});
    check_head("t3_bad_stop");
    check("t3_empty", rx_empty, 1);

    // Randomized frames and formats
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      bp = pe & 1'($urandom_range(0, 1));
      bs = 1'($urandom_range(0, 1));
      parity_en = pe; parity_odd = po;
      send_frame(d, pe, po, bp, bs, 99);
      exp_q.push_back({bs, bp, d});
      check_head("rnd");
      check("rnd_empty", rx_empty, 1);
    end

    // Overrun: five frames into a depth-4 FIFO
    parity_en = 1'b0; parity_odd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(d, 0, 0, 0, 0, 99);
      if (i < 4) exp_q.push_back({2'b00, d});
    end
    check("t4_not_empty", rx_empty, 0);
    check("t4_overrun", overrun, 1);
    clr_err = 1'b1;
    fork
      send_frame(8'h99, 0, 0, 0, 0, 99);
      begin
        step();
        check("t4_cleared", overrun, 0);
        for (int k = 0; k < 12 * bit_clks; k++) begin
          step();
          if (overrun === 1'b1) begin
            clr_err = 1'b0;
            break;
          end
        end
      end
    join
    check("t4_set_wins", overrun, 1);
    clr_err = 1'b0;
    steps(3);
    check("t4_sticky", overrun, 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("t4_clr", overrun, 0);
    for (int i = 0; i < 4; i++) check_head("t4_kept");
    check("t4_drained", rx_empty, 1);

    // False start of 4 ticks, then a good frame
    rx = 1'b0;
    steps(4 * (int'(dvsr) + 1));
    rx = 1'b1;
    steps(2 * bit_clks);
    check("t5_false_start", rx_empty, 1);
    send_frame(8'hC3, 0, 0, 0, 0, 99);
    exp_q.push_back({2'b00, 8'hC3});
    check_head("t5_after_false");

    // Reset mid RX frame, then a full frame
    send_frame(8'($urandom), 0, 0, 0, 0, 5);
    pulse_reset("t5_rst_rx");
    d = 8'($urandom);
    send_frame(d, 0, 0, 0, 0, 99);
    exp_q.push_back({2'b00, d});
    check_head("t5_after_rst");
    check("t5_empty", rx_empty, 1);

    // Tick period at dvsr=325 and bit period on tx
    set_dvsr(325);
    n = 0;
    while (dut.tick !== 1'b1 && n < 400) begin step(); n++; end
    check("t6_tick_seen", dut.tick, 1);
    n = 0;
    do begin step(); n++; end while (dut.tick !== 1'b1 && n < 1000);
    check("t6_tick_period", n, 326);
    w_data = 8'h01; wr_uart = 1'b1; step(); wr_uart = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 10) begin step(); n++; end
    check("t6_start", tx, 0);
    n = 0;
    while (tx !== 1'b1 && n < 5300) begin step(); n++; end
    check("t6_bit0_rise", tx, 1);
    n = 0;
    while (tx === 1'b1 && n < 6000) begin step(); n++; end
    check("t6_bit_period", n, 5216);
    pulse_reset("t6_rst_tx");

    // Lower dvsr below the running count
    n = 0;
    while (dut.tick !== 1'b1 && n < 400) begin step(); n++; end
    steps(100);
    set_dvsr(10);
    #1;
    check("t6_fast_wrap", dut.tick, 1);
    step();
    n = 0;
    while (dut.tick !== 1'b1 && n < 20) begin step(); n++; end
    check("t6_tick_seen2", dut.tick, 1);
    n = 0;
    do begin step(); n++; end while (dut.tick !== 1'b1 && n < 100);
    check("t6_period_11", n, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
